// File: rtl/magnitude_chan_sched.sv
// magnitude_chan_sched: shares one magnitude core among NB_CHAN I/Q streams.
// Each channel owns a one-deep holding slot. A round-robin arbiter issues one
// held sample per clock to the core. A tag line carries the channel number
// alongside the core's latency so that each result returns with its channel.

// Per-channel holding slot: one sample, a pending flag and a sticky overrun flag.
module magnitude_chan_slot #(
    parameter int DATA_SIZE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cap,
    input  logic [DATA_SIZE-1:0] i_i,
    input  logic [DATA_SIZE-1:0] i_q,
    input  logic                 i_grant,
    input  logic                 i_err_clr,
    output logic [DATA_SIZE-1:0] o_i,
    output logic [DATA_SIZE-1:0] o_q,
    output logic                 o_pending,
    output logic                 o_overrun
);
    logic [DATA_SIZE-1:0] r_i;
    logic [DATA_SIZE-1:0] r_q;
    logic                 r_pending;
    logic                 r_overrun;
    logic                 w_lost;

    // A held sample is lost only when it is replaced without having been
    // issued on the same edge. A capture during a grant is not a loss,
    // because the grant takes the old sample.
    assign w_lost = i_cap & r_pending & ~i_grant;

    // Capture the newest sample. Pending survives a grant if a new capture arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_i       <= '0;
            r_q       <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_cap) begin
                r_i <= i_i;
                r_q <= i_q;
            end
            r_pending <= i_cap | (r_pending & ~i_grant);
            r_overrun <= w_lost | (r_overrun & ~i_err_clr);
        end
    end

    assign o_i       = r_i;
    assign o_q       = r_q;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;
endmodule

module magnitude_chan_sched #(
    parameter int DATA_SIZE   = 16,
    parameter int NB_CHAN     = 4,
    parameter int CHAN_W      = 2,
    parameter int MAG_LATENCY = 3
) (
    input  logic                         data_clk_i,
    input  logic                         data_rst_i,
    input  logic [NB_CHAN*DATA_SIZE-1:0] chan_i_i,
    input  logic [NB_CHAN*DATA_SIZE-1:0] chan_q_i,
    input  logic [NB_CHAN-1:0]           chan_en_i,
    output logic [DATA_SIZE-1:0]         mag_i_o,
    output logic [DATA_SIZE-1:0]         mag_q_o,
    output logic                         mag_en_o,
    input  logic [2*DATA_SIZE:0]         mag_data_i,
    input  logic                         mag_en_i,
    output logic [2*DATA_SIZE:0]         data_o,
    output logic                         data_en_o,
    output logic [CHAN_W-1:0]            data_chan_o,
    output logic [NB_CHAN-1:0]           overrun_o,
    output logic                         tag_err_o,
    input  logic                         err_clr_i
);
    logic [NB_CHAN-1:0][DATA_SIZE-1:0] w_hold_i;
    logic [NB_CHAN-1:0][DATA_SIZE-1:0] w_hold_q;
    logic [NB_CHAN-1:0]                w_pending;
    logic [NB_CHAN-1:0]                w_gnt_oh;
    logic                              w_gnt_vld;
    logic [CHAN_W-1:0]                 w_gnt_idx;
    logic [CHAN_W-1:0]                 w_rr_next;

    logic [CHAN_W-1:0]                 r_rr_ptr;
    logic [DATA_SIZE-1:0]              r_mag_i;
    logic [DATA_SIZE-1:0]              r_mag_q;
    logic                              r_mag_en;

    // Tag stage 0 lines up with mag_en_o. Stage MAG_LATENCY lines up with the
    // core's mag_en_i, so the line has MAG_LATENCY+1 entries.
    logic [MAG_LATENCY:0]              r_vld_pipe;
    logic [MAG_LATENCY:0][CHAN_W-1:0]  r_chan_pipe;
    logic                              w_tail_vld;
    logic [CHAN_W-1:0]                 w_tail_chan;

    logic [2*DATA_SIZE:0]              r_data;
    logic                              r_data_en;
    logic [CHAN_W-1:0]                 r_data_chan;
    logic                              r_tag_err;

    for (genvar k = 0; k < NB_CHAN; k++) begin : g_slot
        magnitude_chan_slot #(.DATA_SIZE(DATA_SIZE)) u_slot (
            .i_clk     (data_clk_i),
            .i_rst     (data_rst_i),
            .i_cap     (chan_en_i[k]),
            .i_i       (chan_i_i[k*DATA_SIZE +: DATA_SIZE]),
            .i_q       (chan_q_i[k*DATA_SIZE +: DATA_SIZE]),
            .i_grant   (w_gnt_oh[k]),
            .i_err_clr (err_clr_i),
            .o_i       (w_hold_i[k]),
            .o_q       (w_hold_q[k]),
            .o_pending (w_pending[k]),
            .o_overrun (overrun_o[k])
        );
    end

    // Round-robin search: pick the first pending channel at or after rr_ptr, wrapping around.
    always_comb begin : p_arb
        int v_idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        v_idx     = 0;
        for (int off = 0; off < NB_CHAN; off++) begin
            v_idx = int'(r_rr_ptr) + off;
            if (v_idx >= NB_CHAN) v_idx = v_idx - NB_CHAN;
            if (!w_gnt_vld && w_pending[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = CHAN_W'(v_idx);
            end
        end
        if (w_gnt_vld) w_gnt_oh = NB_CHAN'(1) << w_gnt_idx;
    end

    assign w_rr_next = (int'(w_gnt_idx) == NB_CHAN - 1) ? '0 : w_gnt_idx + CHAN_W'(1);

    // Issue the granted slot to the core. The sample bus holds its value when idle.
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        if (data_rst_i) begin
            r_mag_i  <= '0;
            r_mag_q  <= '0;
            r_mag_en <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            r_mag_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_mag_i  <= w_hold_i[w_gnt_idx];
                r_mag_q  <= w_hold_q[w_gnt_idx];
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Tag line: shift {valid, channel} once per clock so that it tracks the core pipeline.
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        if (data_rst_i) begin
            r_vld_pipe  <= '0;
            r_chan_pipe <= '0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[MAG_LATENCY-1:0], w_gnt_vld};
            r_chan_pipe <= {r_chan_pipe[MAG_LATENCY-1:0], w_gnt_idx};
        end
    end

    assign w_tail_vld  = r_vld_pipe[MAG_LATENCY];
    assign w_tail_chan = r_chan_pipe[MAG_LATENCY];

    // Forward tagged results. A result without a tag is dropped and flagged.
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        if (data_rst_i) begin
            r_data      <= '0;
            r_data_en   <= 1'b0;
            r_data_chan <= '0;
            r_tag_err   <= 1'b0;
        end else begin
            r_data_en <= mag_en_i & w_tail_vld;
            if (mag_en_i && w_tail_vld) begin
                r_data      <= mag_data_i;
                r_data_chan <= w_tail_chan;
            end
            r_tag_err <= (mag_en_i & ~w_tail_vld) | (r_tag_err & ~err_clr_i);
        end
    end

    assign mag_i_o     = r_mag_i;
    assign mag_q_o     = r_mag_q;
    assign mag_en_o    = r_mag_en;
    assign data_o      = r_data;
    assign data_en_o   = r_data_en;
    assign data_chan_o = r_data_chan;
    assign tag_err_o   = r_tag_err;
endmodule

// File: tb/tb_magnitude_chan_sched.sv
// Directed bench for magnitude_chan_sched with a 3-stage I^2+Q^2 core model.
module tb_magnitude_chan_sched;
    localparam int DS = 16;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int ML = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NC*DS-1:0] chan_i, chan_q;
    logic [NC-1:0]    chan_en;
    logic             err_clr;
    logic [DS-1:0]    mag_i, mag_q;
    logic             mag_en;
    logic [2*DS:0]    mag_data;
    logic             mag_en_in;
    logic [2*DS:0]    data;
    logic             data_en;
    logic [CW-1:0]    data_chan;
    logic [NC-1:0]    overrun;
    logic             tag_err;

    logic             spur;
    logic [2*DS:0]    spur_dat;

    int checks   = 0;
    int failures = 0;

    magnitude_chan_sched #(.DATA_SIZE(DS), .NB_CHAN(NC), .CHAN_W(CW), .MAG_LATENCY(ML)) dut (
        .data_clk_i  (clk),
        .data_rst_i  (rst),
        .chan_i_i    (chan_i),
        .chan_q_i    (chan_q),
        .chan_en_i   (chan_en),
        .mag_i_o     (mag_i),
        .mag_q_o     (mag_q),
        .mag_en_o    (mag_en),
        .mag_data_i  (mag_data),
        .mag_en_i    (mag_en_in),
        .data_o      (data),
        .data_en_o   (data_en),
        .data_chan_o (data_chan),
        .overrun_o   (overrun),
        .tag_err_o   (tag_err),
        .err_clr_i   (err_clr)
    );

    // Core model: registered I^2+Q^2 with ML clocks from mag_en_o to mag_en_i.
    logic signed [2*DS:0] ei, eq, sq;
    logic [ML-1:0]        core_vld;
    logic [ML-1:0][2*DS:0] core_dat;
    always_comb begin
        ei = {{(DS+1){mag_i[DS-1]}}, mag_i};
        eq = {{(DS+1){mag_q[DS-1]}}, mag_q};
        sq = ei * ei + eq * eq;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_vld <= '0;
            core_dat <= '0;
        end else begin
            core_vld <= {core_vld[ML-2:0], mag_en};
            core_dat <= {core_dat[ML-2:0], sq};
        end
    end
    assign mag_en_in = core_vld[ML-1] | spur;
    assign mag_data  = spur ? spur_dat : core_dat[ML-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_chan(input int k, input int iv, input int qv);
        chan_i[k*DS +: DS] = DS'(iv);
        chan_q[k*DS +: DS] = DS'(qv);
        chan_en[k] = 1'b1;
    endtask

    initial begin
        chan_i = '0; chan_q = '0; chan_en = '0; err_clr = 1'b0;
        spur = 1'b0; spur_dat = '0;
        #12;
        chk("rst_mag_en", 64'(mag_en), 0);
        chk("rst_mag_i", 64'(mag_i), 0);
        chk("rst_data_en", 64'(data_en), 0);
        chk("rst_data", 64'(data), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_tag_err", 64'(tag_err), 0);
        rst = 1'b0;
        step();

        // All four channels at once, rr_ptr=0: issue order 0,1,2,3
        for (int k = 0; k < NC; k++) drive_chan(k, 10*(k+1), k);
        step();
        chan_en = '0;
        for (int n = 0; n < NC; n++) begin
            step();
            chk("all_issue_en", 64'(mag_en), 1);
            chk("all_issue_i", 64'(mag_i), 64'(10*(n+1)));
            chk("all_issue_q", 64'(mag_q), 64'(n));
        end
        for (int n = 0; n < NC; n++) begin
            step();
            chk("all_res_en", 64'(data_en), 1);
            chk("all_res_data", 64'(data), 64'(100*(n+1)*(n+1) + n*n));
            chk("all_res_chan", 64'(data_chan), 64'(n));
        end
        step();
        chk("all_res_done", 64'(data_en), 0);
        chk("all_no_overrun", 64'(overrun), 0);

        // Single channel 2, I=3 Q=4: result 25 after edge 5
        drive_chan(2, 3, 4);
        step();
        chan_en = '0;
        chk("single_e0_en", 64'(mag_en), 0);
        step();
        chk("single_e1_en", 64'(mag_en), 1);
        chk("single_e1_i", 64'(mag_i), 3);
        chk("single_e1_q", 64'(mag_q), 4);
        step(); step(); step();
        chk("single_e4_den", 64'(data_en), 0);
        step();
        chk("single_e5_den", 64'(data_en), 1);
        chk("single_e5_data", 64'(data), 25);
        chk("single_e5_chan", 64'(data_chan), 2);
        step();
        chk("single_e6_den", 64'(data_en), 0);
        chk("single_e6_hold", 64'(data), 25);

        // rr_ptr=3, channels 0 and 3 pending: order 3 then 0
        drive_chan(0, 5, 1);
        drive_chan(3, 7, 2);
        step();
        chan_en = '0;
        step();
        chk("wrap_first", 64'(mag_i), 7);
        step();
        chk("wrap_second", 64'(mag_i), 5);
        step();
        chk("wrap_idle", 64'(mag_en), 0);
        // rr_ptr now 1: all strobed gives 1,2,3,0
        for (int k = 0; k < NC; k++) drive_chan(k, 100+k, 0);
        step();
        chan_en = '0;
        step(); chk("rr1_issue0", 64'(mag_i), 101);
        step(); chk("rr1_issue1", 64'(mag_i), 102);
        step(); chk("rr1_issue2", 64'(mag_i), 103);
        step(); chk("rr1_issue3", 64'(mag_i), 100);
        for (int n = 0; n < 6; n++) step();

        // Capture and grant on the same channel at the same edge: both issued, no overrun
        drive_chan(2, 33, 0);
        step();
        drive_chan(2, 34, 0);
        step();
        chan_en = '0;
        chk("same_old", 64'(mag_i), 33);
        chk("same_no_ovr", 64'(overrun), 0);
        step();
        chk("same_new_en", 64'(mag_en), 1);
        chk("same_new", 64'(mag_i), 34);
        step();
        chk("same_idle", 64'(mag_en), 0);
        for (int n = 0; n < 6; n++) step();

        // Overrun on chan 1 while chan 0 is granted; set wins over a same-edge clear
        drive_chan(0, 50, 0);
        drive_chan(1, 17, 0);
        step();
        chan_en = '0;
        drive_chan(1, 34, 0);
        err_clr = 1'b1;
        step();
        chan_en = '0;
        err_clr = 1'b0;
        chk("ovr_grant0", 64'(mag_i), 50);
        chk("ovr_set", 64'(overrun), 4'b0010);
        step();
        chk("ovr_issue_b", 64'(mag_i), 34);
        step();
        chk("ovr_a_lost", 64'(mag_en), 0);
        chk("ovr_sticky", 64'(overrun), 4'b0010);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovr_clear", 64'(overrun), 0);
        for (int n = 0; n < 6; n++) step();

        // Spurious mag_en_i with an empty tag line
        spur = 1'b1;
        spur_dat = 33'd123;
        step();
        spur = 1'b0;
        chk("spur_den", 64'(data_en), 0);
        chk("spur_tag_err", 64'(tag_err), 1);
        chk("spur_hold", 64'(data), 1156);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("spur_clear", 64'(tag_err), 0);

        // Reset with two samples in flight
        drive_chan(0, 1, 1);
        drive_chan(1, 2, 2);
        step();
        chan_en = '0;
        step(); step();
        #3 rst = 1'b1;
        #1;
        chk("mrst_mag_en", 64'(mag_en), 0);
        chk("mrst_mag_i", 64'(mag_i), 0);
        chk("mrst_mag_q", 64'(mag_q), 0);
        chk("mrst_data", 64'(data), 0);
        chk("mrst_chan", 64'(data_chan), 0);
        chk("mrst_den", 64'(data_en), 0);
        #10 rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("mrst_quiet_den", 64'(data_en), 0);
        end
        chk("mrst_quiet_tagerr", 64'(tag_err), 0);
        drive_chan(3, 6, 8);
        step();
        chan_en = '0;
        step();
        chk("post_issue_en", 64'(mag_en), 1);
        chk("post_issue_i", 64'(mag_i), 6);
        step(); step(); step();
        chk("post_e4_den", 64'(data_en), 0);
        step();
        chk("post_den", 64'(data_en), 1);
        chk("post_data", 64'(data), 100);
        chk("post_chan", 64'(data_chan), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
